// File: rtl/bram_cmd_sequencer_if.sv
// bram_cmd_sequencer_if: serial command pins plus BRAM port-A bus of the command sequencer.
interface bram_cmd_sequencer_if #(parameter int ADDR_W = 10, parameter int DATA_W = 8);
  logic              di;
  logic              stb;
  logic              do_o;
  logic              busy;
  logic              err;
  logic              bram_en;
  logic              bram_we;
  logic              bram_regce;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;
  modport master (output di, stb, bram_dout,
                  input  do_o, busy, err, bram_en, bram_we, bram_regce, bram_addr, bram_din);
  modport slave  (input  di, stb, bram_dout,
                  output do_o, busy, err, bram_en, bram_we, bram_regce, bram_addr, bram_din);
endinterface

// File: rtl/bram_cmd_sequencer.sv
// bram_cmd_sequencer: decodes serial WRITE/READ/FILL frames into RAMB36E1 port-A accesses.
module bram_cmd_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int DOA_REG = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  bram_cmd_sequencer_if.slave  bus
);
  localparam int CMD_W = 2 + ADDR_W + DATA_W;
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, CAPTURE, FILL} state_t;
  state_t            state_q, state_d;
  logic [CMD_W-1:0]  frame_q, frame_d;
  logic [DATA_W-1:0] result_q, result_d, din_q, din_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d, we_q, we_d, regce_q, regce_d, busy_q, busy_d, err_q, err_d;
  logic [1:0]        op;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic              last;
  assign {op, c_addr, c_data} = frame_q;
  assign last = &addr_q;
  always_comb begin
    frame_d  = {frame_q[CMD_W-2:0], bus.di};
    result_d = state_q == CAPTURE ? bus.bram_dout : result_q << 1;
    state_d  = state_q;
    addr_d   = addr_q;
    din_d    = din_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    regce_d  = 1'b0;
    err_d    = err_q | (bus.stb && state_q != IDLE);
    case (state_q)
      IDLE: if (bus.stb) begin
        err_d   = op == 2'd0 ? 1'b0 : err_q;
        en_d    = op != 2'd0;
        we_d    = op[0];
        addr_d  = op != 2'd0 ? c_addr : addr_q;
        din_d   = op[0] ? c_data : din_q;
        state_d = op == 2'd1 ? WR : op == 2'd2 ? RD_ISSUE : op == 2'd3 ? FILL : IDLE;
      end
      RD_ISSUE: begin
        state_d = DOA_REG != 0 ? RD_WAIT : CAPTURE;
        regce_d = DOA_REG != 0;
      end
      RD_WAIT: state_d = CAPTURE;
      // FILL stops at the top address instead of wrapping to 0
      FILL: if (last) state_d = IDLE;
      else begin
        addr_d = addr_q + 1'b1;
        en_d   = 1'b1;
        we_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      result_q <= '0;
      din_q    <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      regce_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      result_q <= result_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      we_q     <= we_d;
      regce_q  <= regce_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end
  assign bus.do_o       = result_q[DATA_W-1];
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.bram_en    = en_q;
  assign bus.bram_we    = we_q;
  assign bus.bram_regce = regce_q;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_din   = din_q;
endmodule

// File: tb/tb_bram_cmd_sequencer.sv
// tb_bram_cmd_sequencer: directed checks of both read latencies against behavioural BRAM models.
module tb_bram_cmd_sequencer;
  logic clk, rst_n;
  int   pass_cnt, total_cnt;
  bram_cmd_sequencer_if #(.ADDR_W(10), .DATA_W(8)) b0 (), b1 ();
  bram_cmd_sequencer #(.ADDR_W(10), .DATA_W(8), .DOA_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  bram_cmd_sequencer #(.ADDR_W(10), .DATA_W(8), .DOA_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];
  logic [7:0] raw0 = '0;
  logic [7:0] raw1 = '0;
  logic [7:0] oreg1 = '0;
  int         wr0 = 0;
  always @(posedge clk) begin
    if (b0.bram_en && b0.bram_we) begin
      mem0[b0.bram_addr] <= b0.bram_din;
      wr0 <= wr0 + 1;
    end
    if (b0.bram_en && !b0.bram_we) raw0 <= mem0[b0.bram_addr];
    if (b1.bram_en && b1.bram_we) mem1[b1.bram_addr] <= b1.bram_din;
    if (b1.bram_en && !b1.bram_we) raw1 <= mem1[b1.bram_addr];
    if (b1.bram_regce) oreg1 <= raw1;
  end
  assign b0.bram_dout = raw0;
  assign b1.bram_dout = oreg1;

  function automatic logic [23:0] o0();
    return {b0.do_o, b0.busy, b0.err, b0.bram_en, b0.bram_we, b0.bram_regce, b0.bram_addr, b0.bram_din};
  endfunction
  function automatic logic [23:0] o1();
    return {b1.do_o, b1.busy, b1.err, b1.bram_en, b1.bram_we, b1.bram_regce, b1.bram_addr, b1.bram_din};
  endfunction

  task automatic drive(input logic d, input logic s);
    b0.di = d; b1.di = d; b0.stb = s; b1.stb = s;
  endtask

  // returns at the falling edge inside cycle N+1
  task automatic send(input logic [1:0] op, input logic [9:0] a, input logic [7:0] d);
    logic [19:0] f;
    f = {op, a, d};
    for (int i = 19; i >= 0; i--) begin
      @(negedge clk); drive(f[i], 1'b0);
    end
    @(negedge clk); drive(1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive(1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    total_cnt++;
    if ({o0(), o1()} !== 48'h0) $display("FAIL reset_hold got %h/%h want 0", o0(), o1());
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(1'($urandom_range(1)), 1'b0);
    end
    total_cnt++;
    if ({o0(), o1()} !== 48'h0) $display("FAIL reset_release got %h/%h want 0", o0(), o1());
    else pass_cnt++;
  endtask

  task automatic test_write();
    int w;
    w = wr0;
    send(2'd1, 10'h005, 8'hA5);
    total_cnt++;
    if ({b0.bram_en, b0.bram_we, b0.busy, b0.bram_addr, b0.bram_din} !== {3'b111, 10'h005, 8'hA5})
      $display("FAIL write_n1 got en%b we%b busy%b addr%h din%h want 1 1 1 005 a5",
               b0.bram_en, b0.bram_we, b0.busy, b0.bram_addr, b0.bram_din);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({b0.bram_en, b0.bram_we, b0.busy} !== 3'b000)
      $display("FAIL write_n2 got en%b we%b busy%b want 000", b0.bram_en, b0.bram_we, b0.busy);
    else pass_cnt++;
    total_cnt++;
    if (wr0 - w !== 1 || mem0[5] !== 8'hA5) $display("FAIL write_count got %0d/%h want 1/a5", wr0 - w, mem0[5]);
    else pass_cnt++;
  endtask

  task automatic test_read();
    logic [10:0] do0, do1, bz0, bz1, rc0, rc1, en0;
    send(2'd2, 10'h005, 8'h00);
    total_cnt++;
    if ({b0.bram_en, b0.bram_we, b0.bram_addr, b1.bram_en, b1.bram_we, b1.bram_addr} !== {2'b10, 10'h005, 2'b10, 10'h005})
      $display("FAIL read_issue got en%b we%b addr%h / en%b we%b addr%h want 1 0 005",
               b0.bram_en, b0.bram_we, b0.bram_addr, b1.bram_en, b1.bram_we, b1.bram_addr);
    else pass_cnt++;
    for (int k = 1; k <= 11; k++) begin
      do0 = {do0[9:0], b0.do_o}; do1 = {do1[9:0], b1.do_o};
      bz0 = {bz0[9:0], b0.busy}; bz1 = {bz1[9:0], b1.busy};
      rc0 = {rc0[9:0], b0.bram_regce}; rc1 = {rc1[9:0], b1.bram_regce};
      en0 = {en0[9:0], b0.bram_en};
      @(negedge clk);
    end
    total_cnt++;
    if (do0 !== 11'b00101001010) $display("FAIL read_do_lat1 got %b want 00101001010", do0);
    else pass_cnt++;
    total_cnt++;
    if (do1 !== 11'b00010100101) $display("FAIL read_do_lat2 got %b want 00010100101", do1);
    else pass_cnt++;
    total_cnt++;
    if (bz0 !== 11'b11000000000 || bz1 !== 11'b11100000000)
      $display("FAIL read_busy got %b/%b want 11000000000/11100000000", bz0, bz1);
    else pass_cnt++;
    total_cnt++;
    if (rc0 !== 11'b0 || rc1 !== 11'b01000000000)
      $display("FAIL read_regce got %b/%b want 0/01000000000", rc0, rc1);
    else pass_cnt++;
    total_cnt++;
    if (en0 !== 11'b10000000000) $display("FAIL read_en got %b want 10000000000", en0);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    int         w;
    logic [7:0] m0;
    logic [5:0] en, we, bz;
    w = wr0; m0 = mem0[0];
    send(2'd3, 10'h3FC, 8'h3C);
    for (int k = 1; k <= 6; k++) begin
      en = {en[4:0], b0.bram_en}; we = {we[4:0], b0.bram_we}; bz = {bz[4:0], b0.busy};
      if (k <= 5) begin
        total_cnt++;
        if (b0.bram_addr !== (k <= 4 ? 10'h3FB + 10'(k) : 10'h3FF))
          $display("FAIL fill_addr_%0d got %h want %h", k, b0.bram_addr, (k <= 4 ? 10'h3FB + 10'(k) : 10'h3FF));
        else pass_cnt++;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (en !== 6'b111100 || we !== 6'b111100 || bz !== 6'b111100)
      $display("FAIL fill_strobes got en%b we%b busy%b want 111100", en, we, bz);
    else pass_cnt++;
    total_cnt++;
    if (wr0 - w !== 4 || mem0[0] !== m0 || mem0[10'h3FC] !== 8'h3C || mem0[10'h3FF] !== 8'h3C)
      $display("FAIL fill_writes got %0d writes mem0=%h 3fc=%h 3ff=%h want 4 %h 3c 3c",
               wr0 - w, mem0[0], mem0[10'h3FC], mem0[10'h3FF], m0);
    else pass_cnt++;
  endtask

  task automatic test_err();
    int w, n;
    bit ok;
    w = wr0;
    send(2'd3, 10'h3F8, 8'h11);
    drive(1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0);
    total_cnt++;
    if ({b0.err, b0.busy, b0.bram_addr} !== {2'b11, 10'h3F9})
      $display("FAIL err_set got err%b busy%b addr%h want 1 1 3f9", b0.err, b0.busy, b0.bram_addr);
    else pass_cnt++;
    n = 0;
    while (b0.busy && n < 20) begin
      @(negedge clk); n++;
    end
    total_cnt++;
    if (n !== 7) $display("FAIL err_fill_len got %0d want 7 cycles", n);
    else pass_cnt++;
    ok = 1'b1;
    for (int a = 10'h3F8; a <= 10'h3FF; a++) if (mem0[a] !== 8'h11) ok = 1'b0;
    total_cnt++;
    if (!ok || wr0 - w !== 8 || b0.err !== 1'b1)
      $display("FAIL err_fill_data got ok%b writes %0d err%b want 1 8 1", ok, wr0 - w, b0.err);
    else pass_cnt++;
    send(2'd0, 10'h000, 8'h00);
    total_cnt++;
    if ({b0.err, b0.busy, b0.bram_en} !== 3'b000)
      $display("FAIL err_nop_clear got err%b busy%b en%b want 000", b0.err, b0.busy, b0.bram_en);
    else pass_cnt++;
  endtask

  task automatic test_busy_edge();
    send(2'd1, 10'h005, 8'h5A);
    drive(1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0);
    total_cnt++;
    if ({b0.err, b0.busy, b0.bram_en} !== 3'b100)
      $display("FAIL edge_reject got err%b busy%b en%b want 100", b0.err, b0.busy, b0.bram_en);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({b0.busy, b0.bram_en, mem0[5]} !== {2'b00, 8'h5A})
      $display("FAIL edge_idle got busy%b en%b mem5=%h want 0 0 5a", b0.busy, b0.bram_en, mem0[5]);
    else pass_cnt++;
    send(2'd0, 10'h000, 8'h00);
    total_cnt++;
    if (b0.err !== 1'b0) $display("FAIL edge_nop_clear got err%b want 0", b0.err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fill();
    int         w;
    logic [7:0] m;
    w = wr0; m = mem0[10'h3FE];
    send(2'd3, 10'h3FC, 8'h77);
    @(negedge clk);
    total_cnt++;
    if ({b0.bram_en, b0.bram_addr} !== {1'b1, 10'h3FD})
      $display("FAIL rst_fill_pre got en%b addr%h want 1 3fd", b0.bram_en, b0.bram_addr);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({o0(), o1()} !== 48'h0) $display("FAIL rst_fill_abort got %h/%h want 0", o0(), o1());
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    total_cnt++;
    if (wr0 - w !== 1 || mem0[10'h3FE] !== m || b0.bram_en !== 1'b0)
      $display("FAIL rst_fill_after got %0d writes 3fe=%h en%b want 1 %h 0", wr0 - w, mem0[10'h3FE], b0.bram_en, m);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    drive(1'b0, 1'b0);
    test_reset();
    test_write();
    test_read();
    test_fill();
    test_err();
    test_busy_edge();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
